// File: rtl/mem_pkg.sv
// mem_pkg: shared types, limits and parameter checks for sync_memory_pipelined
package mem_pkg;

    typedef enum logic {INIT, RUN} mem_state_t;

    localparam int MAX_READ_LATENCY = 4;

    function automatic bit latency_ok(input int lat);
        return lat >= 1 && lat <= MAX_READ_LATENCY;
    endfunction

endpackage

// File: rtl/sync_memory_pipelined_if.sv
// sync_memory_pipelined_if: request/response bus of the memory
//   req_valid/req_ready/req_write/req_address/req_data : request channel
//   resp_valid/resp_data                               : response channel (no ready)
//   init_busy                                          : clear sweep in progress
interface sync_memory_pipelined_if #(
    parameter int DATA_WIDTH = 4,
    parameter int ADDR_WIDTH = 3
);
    logic                  req_valid;
    logic                  req_ready;
    logic                  req_write;
    logic [ADDR_WIDTH-1:0] req_address;
    logic [DATA_WIDTH-1:0] req_data;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_data;
    logic                  init_busy;

    modport master (
        output req_valid, req_write, req_address, req_data,
        input  req_ready, resp_valid, resp_data, init_busy
    );

    modport slave (
        input  req_valid, req_write, req_address, req_data,
        output req_ready, resp_valid, resp_data, init_busy
    );
endinterface

// File: rtl/mem_resp_pipe.sv
// mem_resp_pipe: LATENCY-stage {valid, data} response shift register
//   clock, reset        : clock and async active-high reset
//   in_valid, in_data   : response captured at the acceptance edge
//   out_valid, out_data : last stage, drives the response channel
module mem_resp_pipe #(
    parameter int DATA_WIDTH = 4,
    parameter int LATENCY    = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data
);
    logic [LATENCY-1:0]    valid_q;
    logic [DATA_WIDTH-1:0] data_q [LATENCY];

    // Data only moves behind a valid bit, so the output word holds through bubbles.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            for (int i = 0; i < LATENCY; i++) data_q[i] <= '0;
        end else begin
            valid_q[0] <= in_valid;
            if (in_valid) data_q[0] <= in_data;
            for (int i = 1; i < LATENCY; i++) begin
                valid_q[i] <= valid_q[i-1];
                if (valid_q[i-1]) data_q[i] <= data_q[i-1];
            end
        end
    end

    assign out_valid = valid_q[LATENCY-1];
    assign out_data  = data_q[LATENCY-1];
endmodule

// File: rtl/sync_memory_pipelined.sv
// sync_memory_pipelined: single-port memory with post-reset clear and pipelined responses
//   clock, reset : clock and async active-high reset
//   bus          : request/response channel plus init_busy (slave side)
module sync_memory_pipelined
    import mem_pkg::*;
#(
    parameter int                    DATA_WIDTH   = 4,
    parameter int                    ADDR_WIDTH   = 3,
    parameter int                    READ_LATENCY = 1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE   = '0
) (
    input logic                      clock,
    input logic                      reset,
    sync_memory_pipelined_if.slave   bus
);
    localparam int DEPTH = 2 ** ADDR_WIDTH;

    if (!latency_ok(READ_LATENCY)) begin : g_bad_latency
        $error("READ_LATENCY out of range");
    end

    mem_state_t            state_q, state_d;
    logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  accept;
    logic                  we;
    logic [ADDR_WIDTH-1:0] waddr;
    logic [DATA_WIDTH-1:0] wdata;
    logic [DATA_WIDTH-1:0] resp_word;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= INIT;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        if (state_q == INIT) begin
            ptr_d = ptr_q + 1'b1;
            if (ptr_q == '1) state_d = RUN;
        end
    end

    assign accept = bus.req_valid && state_q == RUN;

    // The single write port is shared between the clear sweep and request writes.
    assign we    = state_q == INIT || (accept && bus.req_write);
    assign waddr = state_q == INIT ? ptr_q : bus.req_address;
    assign wdata = state_q == INIT ? INIT_VALUE : bus.req_data;

    always_ff @(posedge clock) begin
        if (we) mem[waddr] <= wdata;
    end

    // Write-first: a write responds with its own data, a read with the stored word.
    assign resp_word = bus.req_write ? bus.req_data : mem[bus.req_address];

    assign bus.req_ready = state_q == RUN;
    assign bus.init_busy = state_q == INIT;

    mem_resp_pipe #(
        .DATA_WIDTH (DATA_WIDTH),
        .LATENCY    (READ_LATENCY)
    ) u_pipe (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (accept),
        .in_data   (resp_word),
        .out_valid (bus.resp_valid),
        .out_data  (bus.resp_data)
    );
endmodule

// File: tb/tb_sync_memory_pipelined.sv
// tb_sync_memory_pipelined: directed checks on a default instance and a wide, latency-3 instance
module tb_sync_memory_pipelined;
    logic clock = 1'b0;
    logic reset_a = 1'b1;
    logic reset_b = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n, s;

    always #5 clock = ~clock;

    sync_memory_pipelined_if #(.DATA_WIDTH(4),  .ADDR_WIDTH(3)) a_if ();
    sync_memory_pipelined_if #(.DATA_WIDTH(16), .ADDR_WIDTH(5)) b_if ();

    sync_memory_pipelined dut_a (
        .clock (clock),
        .reset (reset_a),
        .bus   (a_if.slave)
    );

    sync_memory_pipelined #(
        .DATA_WIDTH   (16),
        .ADDR_WIDTH   (5),
        .READ_LATENCY (3),
        .INIT_VALUE   (16'h5A5A)
    ) dut_b (
        .clock (clock),
        .reset (reset_b),
        .bus   (b_if.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic req_a(input logic v, input logic w, input logic [2:0] addr, input logic [3:0] d);
        a_if.req_valid   = v;
        a_if.req_write   = w;
        a_if.req_address = addr;
        a_if.req_data    = d;
    endtask

    task automatic req_b(input logic v, input logic w, input logic [4:0] addr, input logic [15:0] d);
        b_if.req_valid   = v;
        b_if.req_write   = w;
        b_if.req_address = addr;
        b_if.req_data    = d;
    endtask

    task automatic sweep_a(output int cycles, output int stray);
        cycles = 0;
        stray  = 0;
        do begin
            step();
            cycles++;
            if (a_if.resp_valid) stray++;
        end while (!a_if.req_ready && cycles < 100);
    endtask

    task automatic sweep_b(output int cycles, output int stray);
        cycles = 0;
        stray  = 0;
        do begin
            step();
            cycles++;
            if (b_if.resp_valid) stray++;
        end while (!b_if.req_ready && cycles < 100);
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        req_a(0, 0, 0, 0);
        req_b(0, 0, 0, 0);
        repeat (2) step();
        check("a_rst_ready", a_if.req_ready, 0);
        check("a_rst_busy", a_if.init_busy, 1);
        check("a_rst_rvalid", a_if.resp_valid, 0);
        check("a_rst_rdata", a_if.resp_data, 0);
        // A write held on the bus during the sweep must be ignored.
        req_a(1, 1, 3, 4'hF);
        reset_a = 1'b0;
        sweep_a(n, s);
        a_if.req_valid = 0;
        check("a_clear_cycles", n, 8);
        check("a_busy_done", a_if.init_busy, 0);
        check("a_init_no_resp", s, 0);
        for (int i = 0; i < 8; i++) begin
            req_a(1, 0, 3'(i), 0);
            step();
            check("a_clear_rvalid", a_if.resp_valid, 1);
            check("a_clear_rdata", a_if.resp_data, 0);
        end
        req_a(1, 1, 5, 4'hA);
        step();
        check("a_wr5_valid", a_if.resp_valid, 1);
        check("a_wr5_data", a_if.resp_data, 4'hA);
        req_a(1, 0, 5, 0);
        step();
        check("a_rd5_valid", a_if.resp_valid, 1);
        check("a_rd5_data", a_if.resp_data, 4'hA);
        req_a(0, 0, 0, 0);
        step();
        check("a_idle_valid", a_if.resp_valid, 0);
        check("a_idle_hold", a_if.resp_data, 4'hA);
        req_a(1, 1, 6, 4'h3);
        step();
        check("a_wr6_data", a_if.resp_data, 4'h3);
        req_a(1, 0, 6, 4'hC);
        step();
        check("a_rd6_data", a_if.resp_data, 4'h3);
        req_a(1, 0, 5, 0);
        step();
        check("a_rd5b_data", a_if.resp_data, 4'hA);
        req_a(0, 0, 0, 0);
        reset_a = 1'b1;
        #1;
        check("a_async_ready", a_if.req_ready, 0);
        check("a_async_rdata", a_if.resp_data, 0);
        step();
        reset_a = 1'b0;
        repeat (4) step();
        check("a_mid_init_ready", a_if.req_ready, 0);
        reset_a = 1'b1;
        #1;
        check("a_mid_init_busy", a_if.init_busy, 1);
        step();
        reset_a = 1'b0;
        sweep_a(n, s);
        check("a_reclear_cycles", n, 8);
        req_a(1, 0, 6, 0);
        step();
        req_a(0, 0, 0, 0);
        check("a_reclear_rd6", a_if.resp_data, 0);

        reset_b = 1'b0;
        sweep_b(n, s);
        check("b_clear_cycles", n, 32);
        check("b_busy_done", b_if.init_busy, 0);
        req_b(1, 1, 31, 16'hBEEF);
        step();
        check("b_lat_e0", b_if.resp_valid, 0);
        req_b(1, 0, 31, 0);
        step();
        check("b_lat_e1", b_if.resp_valid, 0);
        req_b(0, 0, 0, 0);
        step();
        check("b_wr_valid", b_if.resp_valid, 1);
        check("b_wr_data", b_if.resp_data, 16'hBEEF);
        step();
        check("b_rd_valid", b_if.resp_valid, 1);
        check("b_rd_data", b_if.resp_data, 16'hBEEF);
        step();
        check("b_idle_valid", b_if.resp_valid, 0);
        check("b_idle_hold", b_if.resp_data, 16'hBEEF);
        req_b(1, 0, 7, 0);
        step();
        req_b(0, 0, 0, 0);
        step();
        check("b_rd7_early", b_if.resp_valid, 0);
        step();
        check("b_rd7_valid", b_if.resp_valid, 1);
        check("b_rd7_data", b_if.resp_data, 16'h5A5A);
        req_b(1, 0, 31, 0);
        step();
        step();
        req_b(0, 0, 0, 0);
        reset_b = 1'b1;
        #1;
        check("b_drop_rvalid", b_if.resp_valid, 0);
        check("b_drop_rdata", b_if.resp_data, 0);
        step();
        check("b_drop_held", b_if.resp_valid, 0);
        step();
        reset_b = 1'b0;
        sweep_b(n, s);
        check("b_reclear_cycles", n, 32);
        check("b_drop_no_resp", s, 0);
        req_b(1, 0, 31, 0);
        step();
        req_b(0, 0, 0, 0);
        repeat (2) step();
        check("b_reclear_valid", b_if.resp_valid, 1);
        check("b_reclear_data", b_if.resp_data, 16'h5A5A);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
